ym2149_bus_writer: RTL and testbench

//  Queued YM2149/AY bus master for the PSG register interface. Accepts register write/read

---
 rtl/ym2149_bus_writer.sv | 188 ++++++++++++++++++
 tb/tb_ym2149_bus_writer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym2149_bus_writer.sv
// Queued YM2149/AY register bus master. Commands wait in a small FIFO and are
// played onto the PSG pins as latch-address, gap, write/read, gap.
module ym2149_bus_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int T_LATCH    = 1,
    parameter int T_GAP      = 1,
    parameter int T_ACCESS   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_rd,
    input  logic [3:0] i_cmd_addr,
    input  logic [7:0] i_cmd_data,
    output logic       o_rd_valid,
    output logic [7:0] o_rd_data,
    output logic       o_busy,
    output logic [7:0] o_da_out,
    output logic       o_da_oe,
    input  logic [7:0] i_da_in,
    output logic       o_bdir,
    output logic       o_bc1,
    output logic       o_bc2
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CNTW   = AW + 1;
    localparam int TMAX_A = (T_LATCH > T_GAP) ? T_LATCH : T_GAP;
    localparam int TMAX   = (TMAX_A > T_ACCESS) ? TMAX_A : T_ACCESS;
    localparam int CW     = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LOAD_LATCH  = CW'(T_LATCH - 1);
    localparam logic [CW-1:0] LOAD_GAP    = CW'(T_GAP - 1);
    localparam logic [CW-1:0] LOAD_ACCESS = CW'(T_ACCESS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_GAP1,
        ST_ACCESS,
        ST_GAP2
    } state_t;

    logic [12:0]     r_fifo [FIFO_DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CNTW-1:0] r_count;
    logic            r_cmdReady;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_cmdRd;
    logic [3:0]      r_cmdAddr;
    logic [7:0]      r_cmdData;
    logic            r_sampleRd;

    logic            r_busy;
    logic            r_rdValid;
    logic [7:0]      r_rdData;
    logic [7:0]      r_daOut;
    logic            r_daOe;
    logic            r_bdir;
    logic            r_bc1;
    logic            r_bc2;

    logic            w_push;
    logic            w_pop;
    logic            w_phaseDone;
    logic [CNTW-1:0] w_countNext;

    assign w_push      = i_rst_n && i_cmd_valid && r_cmdReady;
    assign w_pop       = (r_state == ST_IDLE) && (r_count != '0);
    assign w_phaseDone = (r_cnt == '0);
    assign w_countNext = r_count + CNTW'(w_push) - CNTW'(w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= {i_cmd_rd, i_cmd_addr, i_cmd_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_cmdReady <= 1'b1;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cmdRd    <= 1'b0;
            r_cmdAddr  <= '0;
            r_cmdData  <= '0;
            r_sampleRd <= 1'b0;
            r_busy     <= 1'b0;
            r_rdValid  <= 1'b0;
            r_rdData   <= '0;
            r_daOut    <= '0;
            r_daOe     <= 1'b0;
            r_bdir     <= 1'b0;
            r_bc1      <= 1'b0;
            r_bc2      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count    <= w_countNext;
            r_cmdReady <= (w_countNext != CNTW'(FIFO_DEPTH));
            r_busy     <= (r_state != ST_IDLE) || (r_count != '0);

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_cmdRd, r_cmdAddr, r_cmdData} <= r_fifo[r_rdPtr];
                        r_cnt   <= LOAD_LATCH;
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (w_phaseDone) begin
                        r_cnt   <= LOAD_GAP;
                        r_state <= ST_GAP1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_GAP1: begin
                    if (w_phaseDone) begin
                        r_cnt   <= LOAD_ACCESS;
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_ACCESS: begin
                    if (w_phaseDone) begin
                        r_cnt   <= LOAD_GAP;
                        r_state <= ST_GAP2;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_GAP2: begin
                    if (w_phaseDone) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Pin stage trails r_state by one cycle, so read data is captured
            // at the end of the last cycle the pins actually show the read.
            r_bdir <= (r_state == ST_LATCH) || ((r_state == ST_ACCESS) && !r_cmdRd);
            r_bc1  <= (r_state == ST_LATCH) || ((r_state == ST_ACCESS) && r_cmdRd);
            r_bc2  <= (r_state == ST_LATCH) || (r_state == ST_ACCESS);
            r_daOe <= (r_state == ST_LATCH) || ((r_state == ST_ACCESS) && !r_cmdRd);

            if (r_state == ST_LATCH) begin
                r_daOut <= {4'b0000, r_cmdAddr};
            end else if ((r_state == ST_ACCESS) && !r_cmdRd) begin
                r_daOut <= r_cmdData;
            end else begin
                r_daOut <= 8'h00;
            end

            r_sampleRd <= (r_state == ST_ACCESS) && r_cmdRd && w_phaseDone;
            r_rdValid  <= r_sampleRd;
            if (r_sampleRd) begin
                r_rdData <= i_da_in;
            end
        end
    end

    assign o_cmd_ready = r_cmdReady;
    assign o_busy      = r_busy;
    assign o_rd_valid  = r_rdValid;
    assign o_rd_data   = r_rdData;
    assign o_da_out    = r_daOut;
    assign o_da_oe     = r_daOe;
    assign o_bdir      = r_bdir;
    assign o_bc1       = r_bc1;
    assign o_bc2       = r_bc2;

endmodule

// File: tb/tb_ym2149_bus_writer.sv
// Scoreboard bench for ym2149_bus_writer: one instance with default timing,
// one with stretched phases, both observed by the same bus monitor.
`timescale 1ns/1ps
module tb_ym2149_bus_writer;
    localparam int L1 = 3;
    localparam int G1 = 2;
    localparam int A1 = 4;

    typedef struct {
        int         inst;
        bit         rd;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] rdExp;
        bit         b2b;
    } cmdT;

    logic       clock = 1'b0;
    logic       rstN;
    logic [1:0] cmdValid;
    logic [1:0] cmdReady;
    logic       cmdRd;
    logic [3:0] cmdAddr;
    logic [7:0] cmdData;
    logic [7:0] daIn;
    logic [1:0] rdValid;
    logic [7:0] rdData [2];
    logic [1:0] busy;
    logic [7:0] daOut [2];
    logic [1:0] daOe;
    logic [1:0] bdir;
    logic [1:0] bc1;
    logic [1:0] bc2;

    int  checks = 0;
    int  errors = 0;
    bit  sawBackpressure;
    cmdT expQ [$];

    logic [2:0] prevCode [2];
    int         runLen [2];
    bit         afterLatch [2];
    bit         afterAccess [2];
    cmdT        cur [2];
    int         cycle [2];
    int         lastLatch [2];
    int         latchCount [2];

    initial forever #5 clock = ~clock;

    ym2149_bus_writer dut (
        .i_clk(clock), .i_rst_n(rstN),
        .i_cmd_valid(cmdValid[0]), .o_cmd_ready(cmdReady[0]),
        .i_cmd_rd(cmdRd), .i_cmd_addr(cmdAddr), .i_cmd_data(cmdData),
        .o_rd_valid(rdValid[0]), .o_rd_data(rdData[0]), .o_busy(busy[0]),
        .o_da_out(daOut[0]), .o_da_oe(daOe[0]), .i_da_in(daIn),
        .o_bdir(bdir[0]), .o_bc1(bc1[0]), .o_bc2(bc2[0])
    );

    ym2149_bus_writer #(.FIFO_DEPTH(4), .T_LATCH(L1), .T_GAP(G1), .T_ACCESS(A1)) dutSlow (
        .i_clk(clock), .i_rst_n(rstN),
        .i_cmd_valid(cmdValid[1]), .o_cmd_ready(cmdReady[1]),
        .i_cmd_rd(cmdRd), .i_cmd_addr(cmdAddr), .i_cmd_data(cmdData),
        .o_rd_valid(rdValid[1]), .o_rd_data(rdData[1]), .o_busy(busy[1]),
        .o_da_out(daOut[1]), .o_da_oe(daOe[1]), .i_da_in(daIn),
        .o_bdir(bdir[1]), .o_bc1(bc1[1]), .o_bc2(bc2[1])
    );

    function automatic int tLatch(input int k);
        return (k == 0) ? 1 : L1;
    endfunction

    function automatic int tGap(input int k);
        return (k == 0) ? 1 : G1;
    endfunction

    function automatic int tAccess(input int k);
        return (k == 0) ? 1 : A1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Offers one command; cmdValid stays high so consecutive calls form a burst.
    task automatic applyStimulus(input int k, input bit rd, input logic [3:0] addr,
                                 input logic [7:0] data, input bit b2b);
        cmdT item;
        int  waitCycles = 0;
        @(negedge clock);
        cmdValid[k] = 1'b1;
        cmdRd       = rd;
        cmdAddr     = addr;
        cmdData     = data;
        while (!cmdReady[k] && waitCycles < 40) begin
            @(negedge clock);
            waitCycles++;
        end
        if (waitCycles > 0) sawBackpressure = 1'b1;
        if (!cmdReady[k]) begin
            checkOutput("readyTimeout", 0, 1);
            cmdValid[k] = 1'b0;
            return;
        end
        item.inst  = k;
        item.rd    = rd;
        item.addr  = addr;
        item.data  = data;
        item.rdExp = daIn;
        item.b2b   = b2b;
        expQ.push_back(item);
        @(posedge clock);
    endtask

    task automatic dropValid(input int k);
        @(negedge clock);
        cmdValid[k] = 1'b0;
    endtask

    task automatic waitIdle(input int k);
        int n = 0;
        repeat (3) @(negedge clock);
        while ((busy[k] || expQ.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("idleReached", 32'(busy[k] == 1'b0 && expQ.size() == 0), 1);
    endtask

    // Per-cycle bus monitor: phase order, phase lengths, pin contents, read return.
    task automatic monitorStep(input int k);
        logic [2:0] code;
        logic       expRd;
        code = {bdir[k], bc1[k], bc2[k]};
        cycle[k]++;
        if (!rstN) begin
            prevCode[k]    = 3'b000;
            runLen[k]      = 0;
            afterLatch[k]  = 1'b0;
            afterAccess[k] = 1'b0;
            return;
        end
        expRd = (code != prevCode[k]) && (prevCode[k] == 3'b011);
        checkOutput("rdValid", 32'(rdValid[k]), 32'(expRd));
        if (expRd) checkOutput("rdData", 32'(rdData[k]), 32'(cur[k].rdExp));
        if (code != prevCode[k]) begin
            if (prevCode[k] == 3'b111) begin
                checkOutput("latchLen", runLen[k], tLatch(k));
            end else if (prevCode[k] == 3'b101 || prevCode[k] == 3'b011) begin
                checkOutput("accessLen", runLen[k], tAccess(k));
            end else if (prevCode[k] == 3'b000 && afterLatch[k]) begin
                checkOutput("gap1Len", runLen[k], tGap(k));
            end
            runLen[k] = 1;
            if (code == 3'b111) begin
                latchCount[k]++;
                afterLatch[k]  = 1'b1;
                afterAccess[k] = 1'b0;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedLatch", 1, 0);
                end else begin
                    cur[k] = expQ.pop_front();
                    checkOutput("latchInst", k, cur[k].inst);
                    if (cur[k].b2b) begin
                        checkOutput("latchSpacing", cycle[k] - lastLatch[k],
                                    tLatch(k) + 2 * tGap(k) + tAccess(k) + 1);
                    end
                end
                lastLatch[k] = cycle[k];
            end else if (code == 3'b101 || code == 3'b011) begin
                checkOutput("accessAfterGap", 32'(afterLatch[k] && prevCode[k] == 3'b000), 1);
                checkOutput("accessKind", 32'(code), cur[k].rd ? 3 : 5);
                afterLatch[k] = 1'b0;
            end else if (code == 3'b000) begin
                if (prevCode[k] == 3'b101 || prevCode[k] == 3'b011) afterAccess[k] = 1'b1;
            end else begin
                checkOutput("badCode", 32'(code), 0);
            end
        end else begin
            runLen[k]++;
        end
        case (code)
            3'b111: begin
                checkOutput("latchDa", 32'(daOut[k]), 32'({4'h0, cur[k].addr}));
                checkOutput("latchOe", 32'(daOe[k]), 1);
            end
            3'b101: begin
                checkOutput("writeDa", 32'(daOut[k]), 32'(cur[k].data));
                checkOutput("writeOe", 32'(daOe[k]), 1);
            end
            3'b011: checkOutput("readOe", 32'(daOe[k]), 0);
            3'b000: begin
                checkOutput("idleOe", 32'(daOe[k]), 0);
                if (afterAccess[k] && expQ.size() == 0 && runLen[k] <= tGap(k) + 1) begin
                    checkOutput("busyGap2", 32'(busy[k]), 32'(runLen[k] <= tGap(k)));
                end
            end
            default: ;
        endcase
        prevCode[k] = code;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            prevCode[k]    = 3'b000;
            runLen[k]      = 0;
            afterLatch[k]  = 1'b0;
            afterAccess[k] = 1'b0;
            cycle[k]       = 0;
            lastLatch[k]   = 0;
            latchCount[k]  = 0;
        end
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) monitorStep(k);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int lc;
        logic [7:0] burstData [6];

        rstN            = 1'b0;
        cmdValid        = 2'b11;
        cmdRd           = 1'b0;
        cmdAddr         = 4'h3;
        cmdData         = 8'h55;
        daIn            = 8'h00;
        sawBackpressure = 1'b0;

        $display("[TB] reset with cmd_valid held high");
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            checkOutput("rstBusCtl", 32'({bdir[k], bc1[k], bc2[k]}), 0);
            checkOutput("rstDaOe", 32'(daOe[k]), 0);
            checkOutput("rstDaOut", 32'(daOut[k]), 0);
            checkOutput("rstRdValid", 32'(rdValid[k]), 0);
            checkOutput("rstRdData", 32'(rdData[k]), 0);
            checkOutput("rstReady", 32'(cmdReady[k]), 1);
            checkOutput("rstBusy", 32'(busy[k]), 0);
        end
        cmdValid = 2'b00;
        rstN     = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("rstNothingQueued", 32'(busy[0]), 0);
        checkOutput("rstNoLatch", latchCount[0] + latchCount[1], 0);

        $display("[TB] single write reg 6 <- 0x13");
        applyStimulus(0, 1'b0, 4'd6, 8'h13, 1'b0);
        dropValid(0);
        waitIdle(0);

        $display("[TB] reads of reg 7 and reg 15");
        daIn = 8'hA5;
        applyStimulus(0, 1'b1, 4'd7, 8'h00, 1'b0);
        dropValid(0);
        waitIdle(0);
        daIn = 8'h3C;
        applyStimulus(0, 1'b1, 4'd15, 8'hFF, 1'b0);
        dropValid(0);
        waitIdle(0);

        $display("[TB] burst of six writes, regs 8..13");
        lc = latchCount[0];
        sawBackpressure = 1'b0;
        for (int i = 0; i < 6; i++) burstData[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) applyStimulus(0, 1'b0, 4'(8 + i), burstData[i], i > 0);
        dropValid(0);
        checkOutput("burstBackpressure", 32'(sawBackpressure), 1);
        waitIdle(0);
        checkOutput("burstCount", latchCount[0] - lc, 6);

        $display("[TB] stretched timing: write reg 12 <- 0x1F, read, back-to-back");
        applyStimulus(1, 1'b0, 4'd12, 8'h1F, 1'b0);
        dropValid(1);
        waitIdle(1);
        daIn = 8'h5A;
        applyStimulus(1, 1'b1, 4'd2, 8'h00, 1'b0);
        dropValid(1);
        waitIdle(1);
        applyStimulus(1, 1'b0, 4'd3, 8'h44, 1'b0);
        applyStimulus(1, 1'b0, 4'd4, 8'h88, 1'b1);
        dropValid(1);
        waitIdle(1);

        $display("[TB] reset during write access with two queued");
        applyStimulus(0, 1'b0, 4'd1, 8'hAA, 1'b0);
        applyStimulus(0, 1'b0, 4'd2, 8'hBB, 1'b0);
        applyStimulus(0, 1'b0, 4'd3, 8'hCC, 1'b0);
        dropValid(0);
        n = 0;
        while ({bdir[0], bc1[0], bc2[0]} != 3'b101 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("reachedAccess", 32'({bdir[0], bc1[0], bc2[0]}), 5);
        rstN = 1'b0;
        lc   = latchCount[0];
        @(negedge clock);
        checkOutput("abortBusCtl", 32'({bdir[0], bc1[0], bc2[0]}), 0);
        checkOutput("abortDaOe", 32'(daOe[0]), 0);
        checkOutput("abortBusy", 32'(busy[0]), 0);
        checkOutput("abortReady", 32'(cmdReady[0]), 1);
        expQ.delete();
        @(negedge clock);
        rstN = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("abortNoIssue", latchCount[0] - lc, 0);
        checkOutput("abortIdle", 32'(busy[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
